// File: rtl/acc_pkg.sv
// Shared types for the modular accumulator: op/state encodings, pipeline and forwarding records.
package acc_pkg;

  // Records are sized for the largest supported instance; the top zero-extends into them.
  localparam int unsigned ACC_MAX_AW = 32;
  localparam int unsigned ACC_MAX_DW = 64;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_ADD   = 2'd1,
    OP_SUB   = 2'd2,
    OP_RSVD  = 2'd3
  } acc_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } acc_state_e;

  typedef struct packed {
    logic                  valid;
    acc_op_e               op;
    logic [ACC_MAX_AW-1:0] addr;
    logic [ACC_MAX_DW-1:0] data;
    logic [ACC_MAX_DW-1:0] old;
  } acc_stage_t;

  typedef struct packed {
    logic                  valid;
    logic [ACC_MAX_AW-1:0] addr;
    logic [ACC_MAX_DW-1:0] data;
  } acc_hist_t;

  function automatic logic op_is_rmw(acc_op_e op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // Mask keeping the LOGQ low bits, i.e. reduction mod 2**LOGQ.
  function automatic logic [ACC_MAX_DW-1:0] q_mask(int unsigned logq);
    if (logq >= ACC_MAX_DW) return '1;
    return (ACC_MAX_DW'(1) << logq) - ACC_MAX_DW'(1);
  endfunction

endpackage

// File: rtl/pseudo_dpram.sv
// One write port, one read port RAM; registered read data, read-before-write on collisions.
module pseudo_dpram #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // Array itself is never reset; contents are defined only by writes.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/mod_accumulator.sv
// Read-modify-write accumulator over a RAM, results mod 2**LOGQ, with a full-array clear sweep.
module mod_accumulator
  import acc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LOGQ       = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_op,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  clear_req,
  output logic                  busy,
  output logic                  clear_done
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ACC_MAX_DW-1:0] QMASK = q_mask(LOGQ);

  acc_state_e             state;
  logic [ADDR_WIDTH-1:0]  clr_cnt;
  acc_stage_t             s1, s2, s3;
  acc_hist_t              h0, h1;

  acc_op_e                in_op_e;
  logic                   accept;
  logic                   int_rd;
  logic                   pipe_empty;
  logic                   clearing;
  logic [ACC_MAX_DW-1:0]  old_fwd;
  logic [ACC_MAX_DW-1:0]  result;

  logic                   ram_we;
  logic [ADDR_WIDTH-1:0]  ram_waddr;
  logic [DATA_WIDTH-1:0]  ram_wdata;
  logic                   ram_re;
  logic [ADDR_WIDTH-1:0]  ram_raddr;
  logic [DATA_WIDTH-1:0]  ram_rdata;

  assign in_op_e    = acc_op_e'(in_op);
  assign accept     = in_valid && in_ready;
  assign int_rd     = s1.valid && op_is_rmw(s1.op);
  assign pipe_empty = !s1.valid && !s2.valid && !s3.valid;
  assign clearing   = (state == ST_CLEAR);

  // Control FSM; updates win over a same-cycle clear because acceptance uses the current in_ready.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      clr_cnt    <= '0;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          in_ready <= 1'b1;
          if (clear_req) begin
            state    <= ST_DRAIN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (pipe_empty) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
          end
        end
        ST_CLEAR: begin
          clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
          if (clr_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
            state      <= ST_IDLE;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            clear_done <= 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  // Newest matching history entry overrides the RAM value latched in S2.
  always_comb begin
    old_fwd = s3.old;
    if (h1.valid && (h1.addr == s3.addr)) old_fwd = h1.data;
    if (h0.valid && (h0.addr == s3.addr)) old_fwd = h0.data;
    case (s3.op)
      OP_ADD:  result = (old_fwd + s3.data) & QMASK;
      OP_SUB:  result = (old_fwd - s3.data) & QMASK;
      default: result = s3.data & QMASK;
    endcase
  end

  // Pipeline registers, forwarding history and read-handshake flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1       <= '0;
      s2       <= '0;
      s3       <= '0;
      h0       <= '0;
      h1       <= '0;
      rd_ready <= 1'b1;
      rd_valid <= 1'b0;
    end else begin
      if (accept) begin
        s1 <= '{valid: 1'b1,
                op:    in_op_e,
                addr:  ACC_MAX_AW'(in_addr),
                data:  ACC_MAX_DW'(in_data),
                old:   '0};
      end else begin
        s1 <= '0;
      end
      s2     <= s1;
      s3     <= s2;
      s3.old <= ACC_MAX_DW'(ram_rdata);
      h0     <= '{valid: s3.valid, addr: s3.addr, data: result};
      h1     <= h0;
      rd_ready <= !(accept && op_is_rmw(in_op_e));
      rd_valid <= rd_en && rd_ready;
    end
  end

  always_comb begin
    ram_we    = s3.valid;
    ram_waddr = ADDR_WIDTH'(s3.addr);
    ram_wdata = DATA_WIDTH'(result);
    if (clearing) begin
      ram_we    = 1'b1;
      ram_waddr = clr_cnt;
      ram_wdata = '0;
    end
    ram_re    = int_rd || rd_en;
    ram_raddr = int_rd ? ADDR_WIDTH'(s1.addr) : rd_addr;
  end

  assign rd_data = ram_rdata;

  pseudo_dpram #(
    .AW (ADDR_WIDTH),
    .DW (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rstn  (rstn),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_mod_accumulator.sv
// Bench for mod_accumulator: directed tables, hand sequences and a randomized run against a mod-q model.
module tb_mod_accumulator;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned LQ    = 16;
  localparam int unsigned DEPTH = 16;
  localparam longint      Q     = 65536;

  logic          clk = 1'b0;
  logic          rstn;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          clear_req;
  logic          busy;
  logic          clear_done;

  always #5 clk = ~clk;

  mod_accumulator #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .LOGQ       (LQ)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_ready   (rd_ready),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .clear_req  (clear_req),
    .busy       (busy),
    .clear_done (clear_done)
  );

  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } upd_vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] exp;
  } rd_vec_t;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] model [DEPTH];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sequential meaning of one update on a word, in plain integer arithmetic mod q.
  function automatic logic [DW-1:0] apply_op(logic [1:0] op, logic [DW-1:0] old, logic [DW-1:0] d);
    longint o = longint'(old);
    longint v = longint'(d);
    case (op)
      2'd1:    return DW'((o + v) % Q);
      2'd2:    return DW'((((o - v) % Q) + Q) % Q);
      default: return DW'(v % Q);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [1:0] op, logic [AW-1:0] a, logic [DW-1:0] d);
    in_valid = 1'b1;
    in_op    = op;
    in_addr  = a;
    in_data  = d;
    check("in_ready_on_send", 64'(in_ready), 64'(1));
    model[a] = apply_op(op, model[a], d);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (5) tick();
  endtask

  task automatic read_chk(string name, logic [AW-1:0] a, logic [DW-1:0] exp);
    for (int i = 0; i < 8 && !rd_ready; i++) tick();
    check("rd_ready_wait", 64'(rd_ready), 64'(1));
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
    rd_en = 1'b0;
    check({name, "_valid"}, 64'(rd_valid), 64'(1));
    check(name, 64'(rd_data), 64'(exp));
  endtask

  task automatic do_clear();
    int got;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    got = 0;
    for (int c = 0; c < 100 && got == 0; c++) begin
      if (clear_done) got = 1;
      else tick();
    end
    check("init_clear_done", 64'(got), 64'(1));
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    tick();
  endtask

  initial begin
    upd_vec_t upd_tab[$];
    rd_vec_t  rd_tab[$];
    int busy_cyc, done_cnt, overlap, pulses;
    logic prev_rmw, rd_acc, acc;
    logic [1:0] rop;

    rstn = 1'b0; in_valid = 1'b0; in_op = '0; in_addr = '0; in_data = '0;
    rd_en = 1'b0; rd_addr = '0; clear_req = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",   64'(in_ready),   64'(0));
    check("rst_rd_valid",   64'(rd_valid),   64'(0));
    check("rst_rd_data",    64'(rd_data),    64'(0));
    check("rst_busy",       64'(busy),       64'(0));
    check("rst_clear_done", 64'(clear_done), 64'(0));
    rstn = 1'b1;
    tick();
    check("post_rst_in_ready", 64'(in_ready), 64'(1));

    do_clear();

    // Back-to-back write then add on one word.
    send(2'd0, 4'd3, 32'd5);
    send(2'd1, 4'd3, 32'd7);
    settle();
    read_chk("wr_add_addr3", 4'd3, 32'd12);

    upd_tab = '{
      '{2'd1, 4'd0,  32'h0000_FFFF}, '{2'd1, 4'd0,  32'h0000_FFFF},
      '{2'd2, 4'd9,  32'd1},         '{2'd1, 4'd2,  32'd1},
      '{2'd1, 4'd5,  32'd1},         '{2'd1, 4'd2,  32'd1},
      '{2'd3, 4'd7,  32'h0001_2345}, '{2'd0, 4'd8,  32'h000A_BCDE},
      '{2'd2, 4'd3,  32'd20},        '{2'd1, 4'd3,  32'd3},
      '{2'd1, 4'd11, 32'd1},         '{2'd1, 4'd12, 32'd2},
      '{2'd1, 4'd13, 32'd3},         '{2'd1, 4'd11, 32'd4}
    };
    rd_tab = '{
      '{4'd0,  32'hFFFE}, '{4'd1,  32'h0},    '{4'd2,  32'd2},    '{4'd3,  32'hFFFB},
      '{4'd4,  32'h0},    '{4'd5,  32'd1},    '{4'd6,  32'h0},    '{4'd7,  32'h2345},
      '{4'd8,  32'hBCDE}, '{4'd9,  32'hFFFF}, '{4'd10, 32'h0},    '{4'd11, 32'd5},
      '{4'd12, 32'd2},    '{4'd13, 32'd3},    '{4'd14, 32'h0},    '{4'd15, 32'h0}
    };
    foreach (upd_tab[i]) send(upd_tab[i].op, upd_tab[i].addr, upd_tab[i].data);
    settle();
    foreach (rd_tab[i]) read_chk($sformatf("table_addr%0d", rd_tab[i].addr), rd_tab[i].addr, rd_tab[i].exp);

    // External read held while an ADD sits in S1.
    send(2'd1, 4'd4, 32'd1);
    rd_en   = 1'b1;
    rd_addr = 4'd3;
    check("rd_ready_blocked", 64'(rd_ready), 64'(0));
    tick();
    check("rd_valid_blocked", 64'(rd_valid), 64'(0));
    check("rd_ready_free",    64'(rd_ready), 64'(1));
    tick();
    rd_en = 1'b0;
    check("rd_late_valid", 64'(rd_valid), 64'(1));
    check("rd_late_data",  64'(rd_data),  64'(32'hFFFB));
    tick();
    check("rd_valid_one_cycle", 64'(rd_valid), 64'(0));
    send(2'd0, 4'd6, 32'd7);
    check("rd_ready_write_s1", 64'(rd_ready), 64'(1));
    settle();
    read_chk("add_addr4", 4'd4, 32'd1);
    read_chk("write_addr6", 4'd6, 32'd7);

    // Clear with three updates in flight; a second clear_req during busy must be ignored.
    send(2'd1, 4'd1, 32'd9);
    send(2'd1, 4'd1, 32'd9);
    clear_req = 1'b1;
    send(2'd2, 4'd1, 32'd2);
    clear_req = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    check("busy_after_clear_req", 64'(busy), 64'(1));
    busy_cyc = 0; done_cnt = 0; overlap = 0;
    for (int c = 0; c < 60; c++) begin
      if (busy) busy_cyc++;
      if (clear_done) done_cnt++;
      if (busy && in_ready) overlap++;
      clear_req = (c == 10);
      tick();
    end
    clear_req = 1'b0;
    check("clear_busy_min",   64'(busy_cyc >= 19), 64'(1));
    check("clear_busy_max",   64'(busy_cyc <= 20), 64'(1));
    check("clear_done_once",  64'(done_cnt), 64'(1));
    check("clear_ready_low",  64'(overlap), 64'(0));
    check("clear_end_ready",  64'(in_ready), 64'(1));
    for (int i = 0; i < DEPTH; i++) read_chk($sformatf("cleared_addr%0d", i), AW'(i), '0);

    // Randomized traffic against the sequential model.
    for (int r = 0; r < 3; r++) begin
      prev_rmw = 1'b0;
      for (int c = 0; c < 60; c++) begin
        acc      = ($urandom_range(0, 3) != 0);
        rop      = 2'($urandom_range(0, 3));
        in_valid = acc;
        in_op    = rop;
        in_addr  = AW'($urandom_range(0, DEPTH - 1));
        in_data  = $urandom;
        rd_en    = ($urandom_range(0, 2) == 0);
        rd_addr  = AW'($urandom_range(0, DEPTH - 1));
        check("rnd_in_ready", 64'(in_ready), 64'(1));
        check("rnd_rd_ready", 64'(rd_ready), 64'(!prev_rmw));
        rd_acc = rd_en && !prev_rmw;
        if (acc) model[in_addr] = apply_op(rop, model[in_addr], in_data);
        prev_rmw = acc && (rop == 2'd1 || rop == 2'd2);
        tick();
        check("rnd_rd_valid", 64'(rd_valid), 64'(rd_acc));
      end
      in_valid = 1'b0;
      rd_en    = 1'b0;
      settle();
      for (int i = 0; i < DEPTH; i++) read_chk($sformatf("rnd%0d_addr%0d", r, i), AW'(i), model[i]);
    end

    // Reset in the middle of a clear abandons it.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (8) tick();
    check("midclr_busy", 64'(busy), 64'(1));
    rstn = 1'b0;
    #1;
    check("midrst_busy",     64'(busy),       64'(0));
    check("midrst_in_ready", 64'(in_ready),   64'(0));
    check("midrst_rd_valid", 64'(rd_valid),   64'(0));
    check("midrst_rd_data",  64'(rd_data),    64'(0));
    tick();
    rstn = 1'b1;
    tick();
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      if (clear_done || busy) pulses++;
      tick();
    end
    check("abandoned_clear_quiet", 64'(pulses), 64'(0));
    check("abandoned_in_ready",    64'(in_ready), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end, got hang expected finish");
    $fatal(1);
  end

endmodule

// File: doc/mod_accumulator.md
MOD_ACCUMULATOR -- requirements
Module: mod_accumulator

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10: word address width; DEPTH = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: stored word width.
REQ-003 SHALL have parameter LOGQ, default 16: modulus q = 2**LOGQ; LOGQ <= DATA_WIDTH.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports clk and rstn.
REQ-005 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-006 SHALL have port rstn, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1 bit: update request valid.
REQ-008 SHALL have port in_ready, output, 1 bit: update accepted when in_valid and in_ready are both 1 at a clock edge.
REQ-009 SHALL have port in_op, input, 2 bits: 0 WRITE, 1 ADD, 2 SUB, 3 reserved (treated as WRITE).
REQ-010 SHALL have port in_addr, input, ADDR_WIDTH bits: target word.
REQ-011 SHALL have port in_data, input, DATA_WIDTH bits: operand.
REQ-012 SHALL have port rd_en, input, 1 bit: external read request.
REQ-013 SHALL have port rd_addr, input, ADDR_WIDTH bits: external read address.
REQ-014 SHALL have port rd_ready, output, 1 bit: external read accepted when rd_en and rd_ready are both 1.
REQ-015 SHALL have port rd_valid, output, 1 bit: rd_data valid.
REQ-016 SHALL have port rd_data, output, DATA_WIDTH bits: read result.
REQ-017 SHALL have port clear_req, input, 1 bit: single-cycle pulse that requests zeroing of all words.
REQ-018 SHALL have port busy, output, 1 bit: 1 while in the DRAIN or CLEAR state.
REQ-019 SHALL have port clear_done, output, 1 bit: one-cycle pulse when the clear completes.

Function
REQ-020 SHALL process accepted updates in a 3-stage pipeline: S1 issues the RAM read, S2 latches the RAM data, S3 computes the result and writes it back; the RAM write occurs at the 3rd edge after acceptance.
REQ-021 SHALL compute results as follows, with bits above LOGQ forced to 0: WRITE gives in_data mod q; ADD gives (old + in_data) mod q; SUB gives (old - in_data) mod q.
REQ-022 SHALL forward the operand "old" from results written in the preceding 1 or 2 cycles when the address matches, giving priority to the newest result, so that back-to-back updates to the same address produce the exact sequential result.
REQ-023 SHALL, for WRITE, issue no internal read and make no use of forwarding.
REQ-024 SHALL drive rd_ready = 0 in any cycle in which S1 holds a valid ADD or SUB; otherwise rd_ready = 1. Internal reads always take priority over external reads.
REQ-025 SHALL, for each accepted external read, assert rd_valid for exactly one cycle, 1 cycle after acceptance, with rd_data equal to the RAM contents; no forwarding applies to external reads.
REQ-026 SHALL hold in_ready = 1 only in the IDLE state.
REQ-027 SHALL implement an FSM with states IDLE, DRAIN and CLEAR:
- IDLE to DRAIN on clear_req; clear_req is ignored while busy.
- DRAIN to CLEAR once S1 through S3 are all empty.
- In CLEAR, write 0 to addresses 0 .. DEPTH-1, one per cycle, in ascending order.
- After the write to address DEPTH-1: pulse clear_done and return to IDLE.
REQ-028 SHALL give an update presented in the same cycle as clear_req priority over the clear: the update is accepted and then drained before the clear begins.
REQ-029 SHALL permit external reads during DRAIN and CLEAR; the returned data is the current RAM word.
REQ-030 SHALL have the address counter wrap at DEPTH-1 with no overflow side effects.

Reset
REQ-031 SHALL, on rstn = 0, clear immediately: all pipeline valid bits, forwarding history, and the clear counter; the FSM returns to IDLE.
REQ-032 SHALL drive the following reset output values: in_ready = 0 while rstn = 0 and 1 after reset; rd_valid = 0, rd_data = 0, busy = 0, clear_done = 0.
REQ-033 SHALL NOT initialise RAM contents on reset; a reset during CLEAR abandons the clear, and a new clear_req is required to complete it.

Structure
REQ-034 SHALL place the op encoding enum (WRITE, ADD, SUB), the FSM state enum, and the pipeline-stage and history struct typedefs in package acc_pkg.
REQ-035 SHALL instantiate the existing pseudo_dpram as its single sub-module: write port driven by S3 or the clear sweep, read port driven by the S1/external mux.
REQ-036 SHALL keep the forwarding history depth at 2 entries, registered results only.

Verification
REQ-037 SHALL verify: WRITE 5 to addr 3, then ADD 7 to addr 3 on consecutive cycles, then read addr 3 -> rd_data = 12.
REQ-038 SHALL verify: with LOGQ = 16, ADD 0xFFFF to addr 0 twice back-to-back, starting from 0 -> final value 0xFFFE.
REQ-039 SHALL verify: SUB 1 from addr 9 holding 0, LOGQ = 16 -> final value 0xFFFF.
REQ-040 SHALL verify: ADD to addr 2, ADD to addr 5, ADD to addr 2 on three consecutive cycles, each with in_data 1, from 0 -> addr 2 = 2 and addr 5 = 1.
REQ-041 SHALL verify: rd_en held high while an ADD occupies S1 -> rd_ready = 0 in that cycle, and the read completes on the next free cycle.
REQ-042 SHALL verify: clear_req with 3 updates in flight, ADDR_WIDTH = 4 -> the updates complete, busy stays high through DRAIN plus 16 CLEAR cycles, clear_done pulses once, and all 16 words read 0.
